// File: rtl/controle_multiciclo.sv
// Multicycle Moore control unit for the RV64 "principal" datapath.
// Decodes IR contents and sequences PC, IR, register bank, ALU, ALUOut, MDR and memory.
module controle_multiciclo (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        iord,
  output logic        mem_write,
  output logic        mdr_write,
  output logic        alu_out_write,
  output logic        reg_write,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  mux_a_sel,
  output logic [1:0]  mux_b_sel,
  output logic [2:0]  alu_op,
  output logic [4:0]  state_out,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_R_EXEC     = 5'd4,
    S_R_WB       = 5'd5,
    S_I_EXEC     = 5'd6,
    S_I_WB       = 5'd7,
    S_MEM_ADDR   = 5'd8,
    S_LD_READ    = 5'd9,
    S_LD_WAIT    = 5'd10,
    S_LD_WB      = 5'd11,
    S_SD_WRITE   = 5'd12,
    S_BRANCH     = 5'd13,
    S_LUI_WB     = 5'd14,
    S_HALT       = 5'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;

  state_t state, state_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r_add, is_r_sub, is_r_and, is_r_or, is_r_type;
  logic       is_addi, is_ld, is_sd, is_beq, is_bne, is_lui;
  logic       unused_operand_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_operand_bits = ^instr[24:15] ^ ^instr[11:7];

  assign is_r_add  = (opcode == OP_R) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_r_sub  = (opcode == OP_R) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_r_and  = (opcode == OP_R) && (funct3 == 3'b111) && (funct7 == 7'b0000000);
  assign is_r_or   = (opcode == OP_R) && (funct3 == 3'b110) && (funct7 == 7'b0000000);
  assign is_r_type = is_r_add | is_r_sub | is_r_and | is_r_or;
  assign is_addi   = (opcode == OP_I)      && (funct3 == 3'b000);
  assign is_ld     = (opcode == OP_LOAD)   && (funct3 == 3'b011);
  assign is_sd     = (opcode == OP_STORE)  && (funct3 == 3'b011);
  assign is_beq    = (opcode == OP_BRANCH) && (funct3 == 3'b000);
  assign is_bne    = (opcode == OP_BRANCH) && (funct3 == 3'b001);
  assign is_lui    = (opcode == OP_LUI);

  // Asynchronous reset so every enable drops the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET;
    else     state <= state_next;
  end

  assign state_out = state;

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    mdr_write     = 1'b0;
    alu_out_write = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    mux_a_sel     = 2'b00;
    mux_b_sel     = 2'b00;
    alu_op        = ALU_ADD;
    halted        = 1'b0;

    case (state)
      S_RESET: state_next = S_FETCH;

      S_FETCH: begin
        mem_read   = 1'b1;
        state_next = S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        mux_a_sel  = 2'b00;
        mux_b_sel  = 2'b01;
        alu_op     = ALU_ADD;
        state_next = S_DECODE;
      end

      // Precompute the branch target from the latched PC while decoding.
      S_DECODE: begin
        mux_a_sel     = 2'b10;
        mux_b_sel     = 2'b10;
        alu_op        = ALU_ADD;
        alu_out_write = 1'b1;
        if (is_r_type)            state_next = S_R_EXEC;
        else if (is_addi)         state_next = S_I_EXEC;
        else if (is_ld || is_sd)  state_next = S_MEM_ADDR;
        else if (is_beq || is_bne) state_next = S_BRANCH;
        else if (is_lui)          state_next = S_LUI_WB;
        else                      state_next = S_HALT;
      end

      S_R_EXEC: begin
        mux_a_sel     = 2'b01;
        mux_b_sel     = 2'b00;
        alu_out_write = 1'b1;
        if (is_r_and)      alu_op = ALU_AND;
        else if (is_r_or)  alu_op = ALU_OR;
        else if (is_r_sub) alu_op = ALU_SUB;
        else               alu_op = ALU_ADD;
        state_next = S_R_WB;
      end

      S_R_WB, S_I_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b00;
        state_next = S_FETCH;
      end

      S_I_EXEC: begin
        mux_a_sel     = 2'b01;
        mux_b_sel     = 2'b10;
        alu_op        = ALU_ADD;
        alu_out_write = 1'b1;
        state_next    = S_I_WB;
      end

      S_MEM_ADDR: begin
        mux_a_sel     = 2'b01;
        mux_b_sel     = 2'b10;
        alu_op        = ALU_ADD;
        alu_out_write = 1'b1;
        state_next    = is_ld ? S_LD_READ : S_SD_WRITE;
      end

      S_LD_READ: begin
        mem_read   = 1'b1;
        iord       = 1'b1;
        state_next = S_LD_WAIT;
      end

      S_LD_WAIT: begin
        mem_read   = 1'b1;
        iord       = 1'b1;
        mdr_write  = 1'b1;
        state_next = S_LD_WB;
      end

      S_LD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_next = S_FETCH;
      end

      S_SD_WRITE: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        state_next = S_FETCH;
      end

      // Not-taken branches leave the PC+4 written during FETCH_WAIT.
      S_BRANCH: begin
        mux_a_sel  = 2'b01;
        mux_b_sel  = 2'b00;
        alu_op     = ALU_SUB;
        pc_src     = 1'b1;
        pc_write   = (is_beq & zero) | (is_bne & ~zero);
        state_next = S_FETCH;
      end

      S_LUI_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        state_next = S_FETCH;
      end

      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end

      default: state_next = S_RESET;
    endcase
  end

endmodule
